obstacle_feeder: RTL and testbench
==================================

Name: obstacle_feeder

Overview:
Upstream stage of the runner datapath. It generates the scrolling obstacle stream one 2-bit column at a time, replacing the fixed 320-bit obstacle pattern with a seeded, deterministic pseudo-random course. Each column is presented on `col_height`, and the datapath consumes it with a one-cycle `advance` pulse on every scroll tick. Gap spacing, pipe height and pipe width come from a 16-bit LFSR, and a difficulty input shortens the gaps.

Parameters:
- SEED, 16'hACE1, LFSR load value on start; a value of 0 is replaced by 16'h0001.
- MIN_GAP, 3, minimum number of empty columns between pipes; must be ≥1.
- MAX_GAP, 8, maximum number of empty columns between pipes; must be ≥ MIN_GAP and ≤ 31.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  sync level; (re)starts the course from SEED
- halt  in  1  sync level; returns to IDLE and keeps the LFSR value
- advance  in  1  one-cycle pulse: consumer takes the presented column
- difficulty  in  2  subtracted from each newly drawn gap length
- col_valid  out  1  high when col_height is a meaningful column
- col_height  out  2  presented column: 0 = empty, 1..3 = pipe height
- pipe_start  out  1  one-cycle pulse when the first column of a pipe is presented
- pipes_emitted  out  8  count of pipes presented, saturating at 255

Behaviour:
- Clock, reset and priority
  - Everything is clocked on the rising edge of clk.
  - reset (async, immediate):
    - state = IDLE, lfsr = SEED, gap_cnt = 0, width_left = 0
    - col_valid = 0, col_height = 0, pipe_start = 0, pipes_emitted = 0
  - Priority among synchronous inputs: start > halt > advance.
- States: IDLE, GAP, PIPE.
- Column semantics: col_height is one-deep prefetched.
  - It always shows the column the consumer takes on its next advance.
  - On an accepted advance the next column appears the following cycle (latency 1).
  - Consumers sample col_height in the same cycle they assert advance.
- start, from any state:
  - lfsr = SEED, state = GAP, col_height = 0, col_valid = 1
  - gap_cnt = MIN_GAP-1, width_left = 0, pipes_emitted = 0
  - An advance in the same cycle is ignored.
- halt:
  - state = IDLE, col_valid = 0, col_height = 0
  - lfsr and pipes_emitted are held.
- IDLE: advance is ignored and the LFSR does not step.
- LFSR stepping
  - The LFSR steps only on an accepted advance (state GAP or PIPE): Galois right shift, nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0).
  - All random fields below are taken from nxt.
- GAP, on advance:
  - If gap_cnt ≠ 0: present 0, gap_cnt -= 1.
  - Else enter PIPE:
    - h = nxt[1:0], with 0 mapped to 1; present h.
    - width_left = nxt[2] (pipe width is 1 or 2 columns).
    - pipe_start = 1 for one cycle.
    - pipes_emitted += 1, saturating at 255.
- PIPE, on advance:
  - If width_left ≠ 0: present the same h, width_left -= 1.
  - Else: present 0, state = GAP, gap_cnt = G-1, where:
    - span = MAX_GAP-MIN_GAP+1
    - raw = MIN_GAP + (nxt[7:3] mod span)
    - G = max(MIN_GAP, raw - difficulty); 6-bit arithmetic, no underflow.
- Net result: exactly G empty columns between pipes, and MIN_GAP empty columns before the first pipe after start.
- difficulty is sampled only at gap reload, so a change never alters a gap already in progress.
- pipe_start is 0 in every cycle except the one after the advance that entered PIPE.
- reset mid-pipe: everything goes to the reset values and the next start replays the identical course.
- Same SEED + same advance sequence + same difficulty ⇒ bit-identical column stream.

Test Plan:
1. reset pulse, then start at default params → col_valid=1, col_height=0; advances 1–2 present 0; advance 3 presents a height in 1..3 with pipe_start=1; pipes_emitted=1.
2. start, then 200 advances at difficulty=0 → stream matches a cycle-accurate C/Python model of the LFSR/FSM column-for-column; every gap length is in 3..8; every pipe width is 1 or 2.
3. difficulty=3 for the whole run → every gap length is ≥3, and the mean gap is lower than in scenario 2; changing difficulty mid-gap does not change that gap's length.
4. halt in PIPE, assert advance ×5, then start → IDLE ignores the advances (col_valid=0); after start the first 3 columns are 0 and the sequence is identical to scenario 2.
5. start and advance asserted in the same cycle → advance ignored, gap_cnt=2; reset asserted mid-cycle during PIPE → outputs go to 0 immediately, without waiting for a clock edge.
6. 1500 advances → pipes_emitted saturates and holds at 255; SEED=0 build behaves like SEED=1.

Source files
------------

// File: rtl/obstacle_feeder.sv
// obstacle_feeder: generates the scrolling obstacle course one 2-bit column
// at a time from a seeded 16-bit Galois LFSR. The presented column is
// prefetched one deep: col_height always shows what the next advance takes.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   start         (re)start the course from SEED (highest priority)
//   halt          return to idle, keep LFSR and pipe count
//   advance       consumer takes the presented column this cycle
//   difficulty    subtracted from each newly drawn gap length
//   col_valid     col_height holds a meaningful column
//   col_height    0 = empty, 1..3 = pipe height
//   pipe_start    one-cycle pulse when a pipe's first column is presented
//   pipes_emitted saturating count of pipes presented
module obstacle_feeder #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned MIN_GAP = 3,
    parameter int unsigned MAX_GAP = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       halt,
    input  logic       advance,
    input  logic [1:0] difficulty,
    output logic       col_valid,
    output logic [1:0] col_height,
    output logic       pipe_start,
    output logic [7:0] pipes_emitted
);

    localparam int unsigned GW   = 6;
    localparam int unsigned CW   = 5;
    localparam int unsigned SPAN = MAX_GAP - MIN_GAP + 1;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]   TAPS     = 16'hB400;
    localparam logic [GW-1:0] MIN_G    = GW'(MIN_GAP);
    localparam logic [GW-1:0] SPAN_G   = GW'(SPAN);
    localparam logic [CW-1:0] START_CNT = CW'(MIN_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_PIPE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [CW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            width_left_q, width_left_d;
    logic            col_valid_d;
    logic [1:0]      col_height_d;
    logic            pipe_start_d;
    logic [7:0]      pipes_emitted_d;

    logic [15:0]     lfsr_nxt_c;
    logic [1:0]      draw_h_c;
    logic [GW-1:0]   raw_gap_c;
    logic [GW-1:0]   gap_floor_c;
    logic [GW-1:0]   gap_len_c;

    // Random draws, all taken from the post-step LFSR value.
    assign lfsr_nxt_c  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    assign draw_h_c    = (lfsr_nxt_c[1:0] == 2'd0) ? 2'd1 : lfsr_nxt_c[1:0];
    assign raw_gap_c   = MIN_G + (GW'(lfsr_nxt_c[7:3]) % SPAN_G);
    // Difficulty shortens the gap but never below MIN_GAP (no underflow).
    assign gap_floor_c = MIN_G + GW'(difficulty);
    assign gap_len_c   = (raw_gap_c >= gap_floor_c) ? (raw_gap_c - GW'(difficulty)) : MIN_G;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            lfsr_q        <= SEED_EFF;
            gap_cnt_q     <= '0;
            width_left_q  <= 1'b0;
            col_valid     <= 1'b0;
            col_height    <= 2'd0;
            pipe_start    <= 1'b0;
            pipes_emitted <= 8'd0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            gap_cnt_q     <= gap_cnt_d;
            width_left_q  <= width_left_d;
            col_valid     <= col_valid_d;
            col_height    <= col_height_d;
            pipe_start    <= pipe_start_d;
            pipes_emitted <= pipes_emitted_d;
        end
    end

    // Next state: start > halt > advance; advance only acts in GAP/PIPE.
    always_comb begin
        state_d         = state_q;
        lfsr_d          = lfsr_q;
        gap_cnt_d       = gap_cnt_q;
        width_left_d    = width_left_q;
        col_valid_d     = col_valid;
        col_height_d    = col_height;
        pipe_start_d    = 1'b0;
        pipes_emitted_d = pipes_emitted;

        if (start) begin
            state_d         = S_GAP;
            lfsr_d          = SEED_EFF;
            gap_cnt_d       = START_CNT;
            width_left_d    = 1'b0;
            col_valid_d     = 1'b1;
            col_height_d    = 2'd0;
            pipes_emitted_d = 8'd0;
        end else if (halt) begin
            state_d      = S_IDLE;
            col_valid_d  = 1'b0;
            col_height_d = 2'd0;
        end else if (advance) begin
            case (state_q)
                S_GAP: begin
                    lfsr_d = lfsr_nxt_c;
                    if (gap_cnt_q != '0) begin
                        col_height_d = 2'd0;
                        gap_cnt_d    = gap_cnt_q - CW'(1);
                    end else begin
                        state_d      = S_PIPE;
                        col_height_d = draw_h_c;
                        width_left_d = lfsr_nxt_c[2];
                        pipe_start_d = 1'b1;
                        if (pipes_emitted != 8'hFF) begin
                            pipes_emitted_d = pipes_emitted + 8'd1;
                        end
                    end
                end
                S_PIPE: begin
                    lfsr_d = lfsr_nxt_c;
                    // col_height already holds this pipe's height.
                    if (width_left_q) begin
                        width_left_d = 1'b0;
                    end else begin
                        state_d      = S_GAP;
                        col_height_d = 2'd0;
                        // The presented empty column counts as the first of the gap.
                        gap_cnt_d    = CW'(gap_len_c - GW'(1));
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_feeder.sv
// Testbench for obstacle_feeder: directed runs with a scoreboard. The
// stimulus pushes the expected column for every driven cycle; a monitor pops
// and compares one cycle later. A second instance built with SEED=0 runs
// alongside and is checked against a course seeded with 1.
module tb_obstacle_feeder;

    localparam logic [15:0] SEED_A  = 16'hACE1;
    localparam int          MIN_GAP = 3;
    localparam int          MAX_GAP = 8;
    localparam int          SPAN    = MAX_GAP - MIN_GAP + 1;
    localparam int          MAXN    = 2600;

    typedef struct packed {
        logic       valid;
        logic [1:0] h;
        logic       ps;
        logic [7:0] cnt;
    } col_t;

    typedef struct {
        col_t a;
        col_t b;
        int   col;
        int   tag;
    } sb_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       halt;
    logic       advance;
    logic [1:0] difficulty;
    logic       col_valid;
    logic [1:0] col_height;
    logic       pipe_start;
    logic [7:0] pipes_emitted;
    logic       z_valid;
    logic [1:0] z_height;
    logic       z_ps;
    logic [7:0] z_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sb_t        sb[$];
    sb_t        mon_e;
    col_t       mon_ga;
    col_t       mon_gb;
    col_t       crs_a [0:MAXN];
    col_t       crs_b [0:MAXN];
    logic [1:0] run_diff [0:MAXN];
    logic [15:0] lf [0:MAXN];
    logic [1:0] obs [0:MAXN];

    // Hand-derived first columns from ACE1: E270, 7138, 389C (h=1, w=2), 1C4E, 0E27 (gap 7).
    int hand_h   [0:5] = '{0, 0, 0, 1, 1, 0};
    int hand_ps  [0:5] = '{0, 0, 0, 1, 0, 0};
    int hand_cnt [0:5] = '{0, 0, 0, 1, 1, 1};

    int sum2, cnt2, sum3, cnt3;

    obstacle_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .halt          (halt),
        .advance       (advance),
        .difficulty    (difficulty),
        .col_valid     (col_valid),
        .col_height    (col_height),
        .pipe_start    (pipe_start),
        .pipes_emitted (pipes_emitted)
    );

    obstacle_feeder #(.SEED(16'h0000)) dut_z (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .halt          (halt),
        .advance       (advance),
        .difficulty    (difficulty),
        .col_valid     (z_valid),
        .col_height    (z_height),
        .pipe_start    (z_ps),
        .pipes_emitted (z_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, need %0d", name, got, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, need %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic chk_col(input string who, input int tag, input int col, input col_t got, input col_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s phase%0d col%0d: got valid=%0b height=%0d pipe_start=%0b pipes=%0d, need valid=%0b height=%0d pipe_start=%0b pipes=%0d",
                     who, tag, col, got.valid, got.h, got.ps, got.cnt, exp.valid, exp.h, exp.ps, exp.cnt);
        end
    endtask

    function automatic logic [15:0] galois(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic put(input bit sel_b, input int pos, input int h, input bit ps, input int cnt);
        col_t c;
        c.valid = 1'b1;
        c.h     = 2'(h);
        c.ps    = ps;
        c.cnt   = 8'(cnt);
        if (sel_b) crs_b[pos] = c;
        else       crs_a[pos] = c;
    endtask

    // Course builder: lays out gap / pipe segments over the column index,
    // column k being produced by the k-th advance after start.
    task automatic build(input logic [15:0] seed, input int n, input bit sel_b);
        int pos, gap, w, cnt, raw, h;
        lf[0] = (seed == 16'h0000) ? 16'h0001 : seed;
        for (int k = 1; k <= n; k++) lf[k] = galois(lf[k-1]);
        pos = 0;
        cnt = 0;
        gap = MIN_GAP;
        while (pos <= n) begin
            for (int k = 0; k < gap && pos <= n; k++) begin
                put(sel_b, pos, 0, 1'b0, cnt);
                pos++;
            end
            if (pos > n) break;
            h = int'(lf[pos][1:0]);
            if (h == 0) h = 1;
            w = lf[pos][2] ? 2 : 1;
            if (cnt < 255) cnt++;
            for (int k = 0; k < w && pos <= n; k++) begin
                put(sel_b, pos, h, k == 0, cnt);
                pos++;
            end
            if (pos > n) break;
            raw = MIN_GAP + (int'(lf[pos][7:3]) % SPAN);
            gap = raw - int'(run_diff[pos]);
            if (gap < MIN_GAP) gap = MIN_GAP;
        end
    endtask

    task automatic build_all(input int n);
        build(SEED_A, n, 1'b0);
        build(16'h0000, n, 1'b1);
    endtask

    task automatic fill_diff(input logic [1:0] d);
        for (int k = 0; k <= MAXN; k++) run_diff[k] = d;
    endtask

    function automatic sb_t mk(input int k, input int tag, input bit hand);
        sb_t e;
        e.a = crs_a[k];
        if (hand && k <= 5) begin
            e.a.valid = 1'b1;
            e.a.h     = 2'(hand_h[k]);
            e.a.ps    = 1'(hand_ps[k]);
            e.a.cnt   = 8'(hand_cnt[k]);
        end
        e.b   = crs_b[k];
        e.col = k;
        e.tag = tag;
        return e;
    endfunction

    function automatic sb_t mk_idle(input logic [7:0] ca, input logic [7:0] cb, input int tag);
        sb_t e;
        e.a   = '{valid: 1'b0, h: 2'd0, ps: 1'b0, cnt: ca};
        e.b   = '{valid: 1'b0, h: 2'd0, ps: 1'b0, cnt: cb};
        e.col = -1;
        e.tag = tag;
        return e;
    endfunction

    // Called at a negedge; drives one cycle of inputs and queues its expectation.
    task automatic step(input logic s, input logic h, input logic a, input logic [1:0] d, input sb_t e);
        start      = s;
        halt       = h;
        advance    = a;
        difficulty = d;
        sb.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        halt    = 1'b0;
        advance = 1'b0;
    endtask

    task automatic run(input int n, input int tag, input bit hand, input bit adv0);
        step(1'b1, 1'b0, adv0, run_diff[0], mk(0, tag, hand));
        for (int k = 1; k <= n; k++) step(1'b0, 1'b0, 1'b1, run_diff[k], mk(k, tag, hand));
    endtask

    // Gap and pipe-width statistics over the observed stream (trailing run ignored).
    task automatic analyze(input int n, input int hi, output int gsum, output int gcnt);
        int k, s, len;
        bit z, first;
        k = 0;
        first = 1'b1;
        gsum = 0;
        gcnt = 0;
        while (k <= n) begin
            s = k;
            z = (obs[k] == 2'd0);
            while (k <= n && ((obs[k] == 2'd0) == z)) k++;
            if (k > n) break;
            len = k - s;
            if (z && first) chk("lead_gap", len, MIN_GAP);
            else if (z) begin
                chk_rng("gap_len", len, MIN_GAP, hi);
                gsum += len;
                gcnt++;
            end else chk_rng("pipe_width", len, 1, 2);
            first = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},  int'(col_valid), 0);
        chk({tag, "_height"}, int'(col_height), 0);
        chk({tag, "_pstart"}, int'(pipe_start), 0);
        chk({tag, "_pipes"},  int'(pipes_emitted), 0);
        chk({tag, "_z_valid"},  int'(z_valid), 0);
        chk({tag, "_z_height"}, int'(z_height), 0);
        chk({tag, "_z_pstart"}, int'(z_ps), 0);
        chk({tag, "_z_pipes"},  int'(z_cnt), 0);
    endtask

    // Monitor: compares the presented column one cycle after each driven cycle.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e        = sb.pop_front();
            mon_ga.valid = col_valid;
            mon_ga.h     = col_height;
            mon_ga.ps    = pipe_start;
            mon_ga.cnt   = pipes_emitted;
            mon_gb.valid = z_valid;
            mon_gb.h     = z_height;
            mon_gb.ps    = z_ps;
            mon_gb.cnt   = z_cnt;
            chk_col("dut", mon_e.tag, mon_e.col, mon_ga, mon_e.a);
            chk_col("dut_seed0", mon_e.tag, mon_e.col, mon_gb, mon_e.b);
            if (mon_e.col >= 0) obs[mon_e.col] = col_height;
        end
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        halt       = 1'b0;
        advance    = 1'b0;
        difficulty = 2'd0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Start, hand-checked first pipe, then 200 advances at difficulty 0.
        fill_diff(2'd0);
        build_all(200);
        run(200, 2, 1'b1, 1'b0);
        analyze(200, MAX_GAP, sum2, cnt2);

        // Difficulty 3 at every gap reload, 0 on all other advances.
        fill_diff(2'd3);
        build_all(200);
        for (int k = 1; k <= 200; k++) begin
            if (!(crs_a[k].h == 2'd0 && crs_a[k-1].h != 2'd0)) run_diff[k] = 2'd0;
        end
        build_all(200);
        run(200, 3, 1'b0, 1'b0);
        analyze(200, MAX_GAP - 3, sum3, cnt3);
        chk("mean_gap_lower", int'(sum3 * cnt2 < sum2 * cnt3), 1);

        // Halt inside the first pipe, advances while idle, then restart.
        fill_diff(2'd0);
        build_all(200);
        run(3, 4, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'd0, mk_idle(crs_a[3].cnt, crs_b[3].cnt, 4));
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, 1'b1, 2'd0, mk_idle(crs_a[3].cnt, crs_b[3].cnt, 4));
        run(60, 4, 1'b0, 1'b0);

        // Start with advance in the same cycle, then async reset inside a pipe.
        run(3, 5, 1'b0, 1'b1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(20, 5, 1'b0, 1'b0);

        // Long run: pipe count saturates and holds.
        fill_diff(2'd3);
        build_all(2500);
        run(2500, 6, 1'b0, 1'b0);
        chk("saturated_pipes", int'(pipes_emitted), 255);
        chk("saturated_pipes_z", int'(z_cnt), 255);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
